// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared encodings for the paddle controller: movement
//                direction, paddle FSM states and the acceleration threshold.
//  Revision    : 1.0  initial release
// ============================================================================
package pong_pkg;

  // Resolved button direction; UP moves the paddle toward lower positions
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // Paddle movement FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Consecutive repeat steps before the step size doubles (accel build only)
  localparam int ACCEL_THRESH = 8;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer followed by a tick-based debouncer.
//                The debounced level toggles after DEBOUNCE_TICKS consecutive
//                ticks that disagree with it; any agreeing tick restarts.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_level
);

  localparam int CNT_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Synchronize the raw button, then count disagreeing ticks to accept a change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        if (r_sync2 != r_level) begin
          if (r_cnt == c_cnt_last) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_ctrl
//  Description : Paddle position controller. Debounces up/down buttons,
//                steps once on press, auto-repeats while held and saturates
//                at POS_MIN/POS_MAX. Optional macro PADDLE_ACCEL_EN doubles
//                the step after ACCEL_THRESH repeat steps in one hold.
//  Revision    : 1.0  initial release
// ============================================================================
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int POS_W          = 8,
  parameter int POS_MIN        = 0,
  parameter int POS_MAX        = 200,
  parameter int POS_RESET      = 100,
  parameter int STEP           = 1,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [POS_W-1:0] paddle_pos,
  output logic             moved
);

  // Two spare bits keep pos +/- 2*STEP free of wrap during the bound compare
  localparam int EXT_W = POS_W + 2;
  localparam int REP_W = (REPEAT_TICKS < 2) ? 1 : $clog2(REPEAT_TICKS);
  localparam logic [REP_W-1:0] c_rep_last = REP_W'(REPEAT_TICKS - 1);
  localparam logic [EXT_W-1:0] c_min_ext  = EXT_W'(POS_MIN);
  localparam logic [EXT_W-1:0] c_max_ext  = EXT_W'(POS_MAX);

  logic             w_up_lvl;
  logic             w_down_lvl;
  dir_t             w_dir;
  dir_t             r_dir;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_step;
  logic             w_rep_clr;
  logic             w_rep_inc;
  logic [REP_W-1:0] r_rep;
  logic [EXT_W-1:0] w_step_size;
  logic [EXT_W-1:0] w_pos_ext;
  logic [POS_W-1:0] w_pos_nxt;
  logic [POS_W-1:0] r_pos;
  logic             r_moved;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_up (
    .clk     (clk),
    .rst     (reset),
    .i_tick  (tick),
    .i_btn   (btn_up),
    .o_level (w_up_lvl)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_down (
    .clk     (clk),
    .rst     (reset),
    .i_tick  (tick),
    .i_btn   (btn_down),
    .o_level (w_down_lvl)
  );

  // Both or neither button pressed resolves to no movement
  always_comb begin
    w_dir = DIR_NONE;
    if (w_up_lvl && !w_down_lvl)      w_dir = DIR_UP;
    else if (w_down_lvl && !w_up_lvl) w_dir = DIR_DOWN;
  end

  // FSM state register plus the previous direction used to spot changes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir;
    end
  end

  // Next state and step requests; a direction change wins over a tick
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_rep_clr   = 1'b0;
    w_rep_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dir != DIR_NONE) begin
          w_step      = 1'b1;
          w_rep_clr   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_dir == DIR_NONE) begin
          w_rep_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_dir != r_dir) begin
          w_step    = 1'b1;
          w_rep_clr = 1'b1;
        end else if (tick) begin
          if (r_rep == c_rep_last) begin
            w_step    = 1'b1;
            w_rep_clr = 1'b1;
          end else begin
            w_rep_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Repeat-interval tick counter
  always_ff @(posedge clk) begin
    if (reset || w_rep_clr) r_rep <= '0;
    else if (w_rep_inc)     r_rep <= r_rep + 1'b1;
  end

`ifdef PADDLE_ACCEL_EN
  logic [3:0] r_accel;
  logic       w_rep_step;

  // A step in HOLD with unchanged direction is an auto-repeat step
  assign w_rep_step  = w_step && (r_state == ST_HOLD) && (w_dir == r_dir);
  assign w_step_size = (r_accel == 4'(ACCEL_THRESH)) ? EXT_W'(2 * STEP) : EXT_W'(STEP);

  // Count repeat steps in this hold; any non-repeat step or IDLE restarts
  always_ff @(posedge clk) begin
    if (reset || (r_state == ST_IDLE) || (w_step && !w_rep_step))
      r_accel <= '0;
    else if (w_rep_step && (r_accel != 4'(ACCEL_THRESH)))
      r_accel <= r_accel + 4'd1;
  end
`else
  assign w_step_size = EXT_W'(STEP);
`endif

  // Saturating next position in the current direction
  always_comb begin
    w_pos_ext = {2'b00, r_pos};
    w_pos_nxt = r_pos;
    if (w_dir == DIR_UP) begin
      if (w_pos_ext < c_min_ext + w_step_size) w_pos_nxt = POS_W'(POS_MIN);
      else                                     w_pos_nxt = POS_W'(w_pos_ext - w_step_size);
    end else if (w_dir == DIR_DOWN) begin
      if (w_pos_ext + w_step_size > c_max_ext) w_pos_nxt = POS_W'(POS_MAX);
      else                                     w_pos_nxt = POS_W'(w_pos_ext + w_step_size);
    end
  end

  // Position register; moved pulses only when the value really changes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos   <= POS_W'(POS_RESET);
      r_moved <= 1'b0;
    end else begin
      r_moved <= 1'b0;
      if (w_step && (w_pos_nxt != r_pos)) begin
        r_pos   <= w_pos_nxt;
        r_moved <= 1'b1;
      end
    end
  end

  assign paddle_pos = r_pos;
  assign moved      = r_moved;

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_ctrl
//  Description : Directed self-checking bench for paddle_ctrl. Three
//                instances: defaults, POS_RESET=198 and POS_RESET=50.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       up_a = 1'b0, dn_a = 1'b0;
  logic       up_b = 1'b0, dn_b = 1'b0;
  logic       up_c = 1'b0, dn_c = 1'b0;
  logic [7:0] pos_a, pos_b, pos_c;
  logic       mv_a, mv_b, mv_c;
  int         mvc_a = 0, mvc_b = 0, mvc_c = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  paddle_ctrl dut_a (
    .clk(clk), .reset(reset), .tick(tick), .btn_up(up_a), .btn_down(dn_a),
    .paddle_pos(pos_a), .moved(mv_a)
  );

  paddle_ctrl #(.POS_RESET(198)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .btn_up(up_b), .btn_down(dn_b),
    .paddle_pos(pos_b), .moved(mv_b)
  );

  paddle_ctrl #(.POS_RESET(50)) dut_c (
    .clk(clk), .reset(reset), .tick(tick), .btn_up(up_c), .btn_down(dn_c),
    .paddle_pos(pos_c), .moved(mv_c)
  );

  // Count moved pulses of each instance
  always @(negedge clk) begin
    if (mv_a) mvc_a <= mvc_a + 1;
    if (mv_b) mvc_b <= mvc_b + 1;
    if (mv_c) mvc_c <= mvc_c + 1;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // n tick pulses, one every 10 clocks
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (9) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    up_a = 0; dn_a = 0; up_b = 0; dn_b = 0; up_c = 0; dn_c = 0;
    do_reset();
    @(negedge clk);
    checks++; if (pos_a !== 8'd100) begin errors++; $display("FAIL reset_pos_a: got %0d expected 100", pos_a); end
    checks++; if (mv_a !== 1'b0) begin errors++; $display("FAIL reset_moved_a: got %b expected 0", mv_a); end
    checks++; if (pos_b !== 8'd198) begin errors++; $display("FAIL reset_pos_b: got %0d expected 198", pos_b); end
    checks++; if (pos_c !== 8'd50) begin errors++; $display("FAIL reset_pos_c: got %0d expected 50", pos_c); end
  endtask

  task automatic test_hold_up();
    int base;
    do_reset();
    base = mvc_a;
    up_a = 1'b1;
    tick_n(3); settle();
    checks++; if (pos_a !== 8'd100) begin errors++; $display("FAIL up_before_debounce: got %0d expected 100", pos_a); end
    tick_n(1); settle();
    checks++; if (pos_a !== 8'd99) begin errors++; $display("FAIL up_first_step: got %0d expected 99", pos_a); end
    checks++; if (mvc_a - base !== 1) begin errors++; $display("FAIL up_first_pulse: got %0d expected 1", mvc_a - base); end
    tick_n(1); settle();
    checks++; if (pos_a !== 8'd99) begin errors++; $display("FAIL up_repeat_wait: got %0d expected 99", pos_a); end
    tick_n(1); settle();
    checks++; if (pos_a !== 8'd98) begin errors++; $display("FAIL up_repeat_step: got %0d expected 98", pos_a); end
    checks++; if (mvc_a - base !== 2) begin errors++; $display("FAIL up_repeat_pulses: got %0d expected 2", mvc_a - base); end
    up_a = 1'b0;
  endtask

  task automatic test_bounce();
    int base;
    do_reset();
    base = mvc_a;
    for (int i = 0; i < 20; i++) begin
      dn_a = ~dn_a;
      tick_n(2);
    end
    dn_a = 1'b0;
    settle();
    checks++; if (pos_a !== 8'd100) begin errors++; $display("FAIL bounce_pos: got %0d expected 100", pos_a); end
    checks++; if (mvc_a - base !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d expected 0", mvc_a - base); end
  endtask

  task automatic test_saturate();
    int base;
    do_reset();
    base = mvc_b;
    dn_b = 1'b1;
    tick_n(4); settle();
    checks++; if (pos_b !== 8'd199) begin errors++; $display("FAIL sat_first: got %0d expected 199", pos_b); end
    tick_n(2); settle();
    checks++; if (pos_b !== 8'd200) begin errors++; $display("FAIL sat_reach_max: got %0d expected 200", pos_b); end
    tick_n(6); settle();
    checks++; if (pos_b !== 8'd200) begin errors++; $display("FAIL sat_hold_max: got %0d expected 200", pos_b); end
    checks++; if (mvc_b - base !== 2) begin errors++; $display("FAIL sat_pulses: got %0d expected 2", mvc_b - base); end
    dn_b = 1'b0;
  endtask

  task automatic test_both_buttons();
    int  base;
    logic found;
    do_reset();
    base = mvc_a;
    up_a = 1'b1; dn_a = 1'b1;
    tick_n(6); settle();
    checks++; if (pos_a !== 8'd100) begin errors++; $display("FAIL both_no_move: got %0d expected 100", pos_a); end
    up_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      tick_n(1); settle();
      if (pos_a == 8'd101) found = 1'b1;
    end
    checks++; if (pos_a !== 8'd101) begin errors++; $display("FAIL both_release_step: got %0d expected 101", pos_a); end
    checks++; if (mvc_a - base !== 1) begin errors++; $display("FAIL both_pulses: got %0d expected 1", mvc_a - base); end
    dn_a = 1'b0;
  endtask

  task automatic test_reset_mid_press();
    dn_a = 1'b1;
    do_reset();
    tick_n(6); settle();
    checks++; if (pos_a !== 8'd102) begin errors++; $display("FAIL midpress_pre: got %0d expected 102", pos_a); end
    do_reset();
    settle();
    checks++; if (pos_a !== 8'd100) begin errors++; $display("FAIL midpress_reset: got %0d expected 100", pos_a); end
    tick_n(3); settle();
    checks++; if (pos_a !== 8'd100) begin errors++; $display("FAIL midpress_redebounce: got %0d expected 100", pos_a); end
    tick_n(1); settle();
    checks++; if (pos_a !== 8'd101) begin errors++; $display("FAIL midpress_step: got %0d expected 101", pos_a); end
    dn_a = 1'b0;
  endtask

  task automatic test_back_to_back_steps();
    int exp;
    do_reset();
    dn_c = 1'b1;
    tick_n(4); settle();
    checks++; if (pos_c !== 8'd51) begin errors++; $display("FAIL accel_first: got %0d expected 51", pos_c); end
    for (int k = 1; k <= 10; k++) begin
      tick_n(2); settle();
`ifdef PADDLE_ACCEL_EN
      exp = (k <= 8) ? 51 + k : 59 + 2 * (k - 8);
`else
      exp = 51 + k;
`endif
      checks++;
      if (pos_c !== 8'(exp)) begin
        errors++;
        $display("FAIL accel_step%0d: got %0d expected %0d", k, pos_c, exp);
      end
    end
    dn_c = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_up();
    test_bounce();
    test_saturate();
    test_both_buttons();
    test_reset_mid_press();
    test_back_to_back_steps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
